// File: rtl/or_pkg.sv
// Shared constants and helpers for the or_2x1 primitive.
package or_pkg;

    localparam int unsigned WIDTH_DEF = 1;
    localparam int unsigned CNT_W_DEF = 8;

    // Saturating increment of a w-bit counter carried in a 32-bit container (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned w);
        logic [31:0] max_val;
        if (w >= 32) begin
            max_val = '1;
        end else begin
            max_val = (32'(1) << w) - 32'(1);
        end
        if (cnt >= max_val) begin
            return max_val;
        end
        return cnt + 32'(1);
    endfunction

endpackage

// File: rtl/or_2x1_cell.sv
// Single-bit OR cell; leaf of the or_2x1 bit slice array.
module or_cell (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    assign y_o = a_i | b_i;

endmodule

// File: rtl/or_2x1.sv
// Bitwise 2-input OR with a live combinational output plus a registered copy,
// a sticky ever-high accumulator and a saturating high-cycle counter.
module or_2x1
    import or_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_vld,
    output logic [WIDTH-1:0] sticky,
    output logic [CNT_W-1:0] hi_cnt
);

    logic [WIDTH-1:0] or_w;

    logic             run_q;
    logic [WIDTH-1:0] data_q,   data_d;
    logic             vld_q,    vld_d;
    logic [WIDTH-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    // One OR cell per bit; the result drives both the live output and the register stage.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        or_cell u_cell (
            .a_i (a[i]),
            .b_i (b[i]),
            .y_o (or_w[i])
        );
    end

    assign out = or_w;

    // Next-state: capture on en, clr wins over en for sticky/counter; idle in the reset-release cycle.
    always_comb begin
        data_d   = data_q;
        vld_d    = vld_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (run_q) begin
            if (en) begin
                data_d = or_w;
                vld_d  = 1'b1;
            end else begin
                vld_d  = 1'b0;
            end
            if (clr) begin
                sticky_d = '0;
                cnt_d    = '0;
            end else if (en) begin
                sticky_d = sticky_q | or_w;
                if (|or_w) begin
                    cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
                end
            end
        end
    end

    // Clocked state with asynchronous active-low reset; run_q marks the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            data_q   <= '0;
            vld_q    <= 1'b0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            run_q    <= 1'b1;
            data_q   <= data_d;
            vld_q    <= vld_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_q   = data_q;
    assign out_vld = vld_q;
    assign sticky  = sticky_q;
    assign hi_cnt  = cnt_q;

endmodule

// File: tb/tb_or_2x1.sv
// Self-checking bench for or_2x1: a 1-bit/2-bit-counter instance and a 4-bit/8-bit-counter instance.
module tb_or_2x1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic [3:0] a4 = 4'd0, b4 = 4'd0;

    logic       out1, out_q1, vld1, st1;
    logic [1:0] cnt1;
    logic [3:0] out4, out_q4, st4;
    logic       vld4;
    logic [7:0] cnt4;

    int checks = 0;
    int failures = 0;

    // Behavioural model state (plain integers).
    int  m_q1 = 0, m_st1 = 0, m_cnt1 = 0;
    int  m_q4 = 0, m_st4 = 0, m_cnt4 = 0;
    int  m_vld = 0;
    bit  m_run = 0;

    or_2x1 #(.WIDTH(1), .CNT_W(2)) u_d1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .en(en), .clr(clr),
        .out(out1), .out_q(out_q1), .out_vld(vld1), .sticky(st1), .hi_cnt(cnt1)
    );

    or_2x1 #(.WIDTH(4), .CNT_W(8)) u_d4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .en(en), .clr(clr),
        .out(out4), .out_q(out_q4), .out_vld(vld4), .sticky(st4), .hi_cnt(cnt4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: apply the behavioural rules at each edge, reset asynchronously.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_vld = 0;
            m_q1 = 0; m_st1 = 0; m_cnt1 = 0;
            m_q4 = 0; m_st4 = 0; m_cnt4 = 0;
        end else if (!m_run) begin
            m_run = 1;
        end else begin
            if (en) begin
                m_q1 = int'(a1 | b1);
                m_q4 = int'(a4 | b4);
                m_vld = 1;
            end else begin
                m_vld = 0;
            end
            if (clr) begin
                m_st1 = 0; m_cnt1 = 0; m_st4 = 0; m_cnt4 = 0;
            end else if (en) begin
                m_st1 = m_st1 | int'(a1 | b1);
                m_st4 = m_st4 | int'(a4 | b4);
                if ((a1 | b1) != 1'b0) m_cnt1 = (m_cnt1 < 3) ? m_cnt1 + 1 : 3;
                if ((a4 | b4) != 4'd0) m_cnt4 = (m_cnt4 < 255) ? m_cnt4 + 1 : 255;
            end
        end
    end

    // Compare every output of both instances against the model on each falling edge.
    always @(negedge clk) begin
        check("out1",    32'(out1),   32'(a1 | b1));
        check("out4",    32'(out4),   32'(a4 | b4));
        check("out_q1",  32'(out_q1), 32'(m_q1));
        check("out_q4",  32'(out_q4), 32'(m_q4));
        check("vld1",    32'(vld1),   32'(m_vld));
        check("vld4",    32'(vld4),   32'(m_vld));
        check("sticky1", 32'(st1),    32'(m_st1));
        check("sticky4", 32'(st4),    32'(m_st4));
        check("hi_cnt1", 32'(cnt1),   32'(m_cnt1));
        check("hi_cnt4", 32'(cnt4),   32'(m_cnt4));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] tt_in [4];
        logic       tt_out [4];
        logic [1:0] sat_exp [5];
        tt_in  = '{2'b00, 2'b01, 2'b10, 2'b11};
        tt_out = '{1'b0, 1'b1, 1'b1, 1'b1};
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        #2 rst_n = 1'b0;

        // Truth table of the combinational path, held in reset.
        for (int i = 0; i < 4; i++) begin
            a1 = tt_in[i][1];
            b1 = tt_in[i][0];
            #100;
            check("truth_table", 32'(out1), 32'(tt_out[i]));
        end

        // Release reset; the first edge performs no capture.
        @(posedge clk); #1;
        rst_n = 1'b1;
        en = 1'b1; a1 = 1'b1; b1 = 1'b0;
        step();
        check("release_edge_vld", 32'(vld1), 32'd0);
        check("release_edge_q",   32'(out_q1), 32'd0);
        step();
        check("reg_q",   32'(out_q1), 32'd1);
        check("reg_vld", 32'(vld1),   32'd1);
        en = 1'b0;
        step();
        check("hold_q",   32'(out_q1), 32'd1);
        check("hold_vld", 32'(vld1),   32'd0);

        // Saturation of the 2-bit counter.
        clr = 1'b1;
        step();
        check("clr_cnt1", 32'(cnt1), 32'd0);
        clr = 1'b0; en = 1'b1; a1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("sat_cnt1", 32'(cnt1), 32'(sat_exp[i]));
        end

        // Sticky accumulation on the 4-bit instance.
        a1 = 1'b0;
        a4 = 4'b0001; b4 = 4'b0000;
        step();
        a4 = 4'b0000; b4 = 4'b1000;
        step();
        check("sticky4_acc", 32'(st4),  32'h9);
        check("hi_cnt4_acc", 32'(cnt4), 32'd2);
        b4 = 4'b0000; clr = 1'b1;
        step();
        check("sticky4_clr", 32'(st4),  32'd0);
        check("hi_cnt4_clr", 32'(cnt4), 32'd0);

        // Simultaneous clr and en: capture proceeds, accumulators clear.
        a1 = 1'b1; b1 = 1'b0;
        step();
        check("clr_en_q",      32'(out_q1), 32'd1);
        check("clr_en_cnt",    32'(cnt1),   32'd0);
        check("clr_en_sticky", 32'(st1),    32'd0);

        // Asynchronous reset mid-run with inputs high.
        clr = 1'b0; a1 = 1'b1; b1 = 1'b1;
        step();
        step();
        check("pre_rst_cnt1", 32'(cnt1), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_q",      32'(out_q1), 32'd0);
        check("rst_vld",    32'(vld1),   32'd0);
        check("rst_sticky", 32'(st1),    32'd0);
        check("rst_cnt",    32'(cnt1),   32'd0);
        check("rst_out",    32'(out1),   32'd1);
        #20;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
